// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit with a small in-order instruction buffer
//
// Purpose:
//   Fetches 16-bit instruction words from a combinational instruction memory,
//   one per cycle, into a DEPTH-entry FIFO and presents the head entry to
//   decode with its byte address and address + 2. A redirect flushes the
//   buffer and restarts fetching at the target.
//
// Parameters:
//   DEPTH     number of buffer entries (1..4)
//   RESET_PC  byte address fetched first after reset (bit 0 ignored)
//
// Optional feature:
//   FETCH_HALT_DETECT_EN  when defined, a fetched word with opcode
//                         bits [15:11] == 5'b00000 is a HALT: it is still
//                         delivered, but fetching stops until a redirect or
//                         reset. When undefined, halted is tied to 0.
//
// Ports:
//   clk             in   clock, rising edge
//   rst             in   asynchronous active-low reset
//   imem_addr       out  [15:0] byte address to instruction memory (current PC)
//   imem_en         out  read enable, high only in a fetching cycle
//   imem_rdata      in   [15:0] instruction word for imem_addr, same cycle
//   redirect_valid  in   one-cycle branch/jump redirect request
//   redirect_pc     in   [15:0] redirect target byte address
//   inst_valid      out  buffer head holds a valid instruction
//   inst_ready      in   decode accepts the head this cycle
//   inst_out        out  [15:0] head instruction (0 when empty)
//   pc_out          out  [15:0] byte address of inst_out (0 when empty)
//   pc_plus2_out    out  [15:0] pc_out + 2 modulo 2^16 (0 when empty)
//   halted          out  fetching stopped on a HALT instruction

module fetch_unit #(
  parameter int          DEPTH    = 2,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_addr,
  output logic        imem_en,
  input  logic [15:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [15:0] inst_out,
  output logic [15:0] pc_out,
  output logic [15:0] pc_plus2_out,
  output logic        halted
);

  localparam int          PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0]  DEPTH_C = 3'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [15:0]      r_pc;
  logic [2:0]       r_count;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [15:0]      r_buf_inst [DEPTH];
  logic [15:0]      r_buf_pc   [DEPTH];

  logic [15:0] w_pc;
  logic        w_not_empty;
  logic        w_not_full;
  logic        w_pop;
  logic        w_push;
  logic        w_halted;
  logic        w_is_halt;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  assign w_pc        = r_pc & 16'hFFFE;
  assign w_not_empty = (r_count != 3'd0);
  assign w_not_full  = (r_count < DEPTH_C);

  // A redirect kills both the pop and the push of its cycle. Gating with rst
  // keeps imem_en low for the whole time reset is held, not just after an edge.
  assign w_pop  = w_not_empty & inst_ready & ~redirect_valid;
  assign w_push = rst & ~w_halted & ~redirect_valid & (w_not_full | w_pop);

`ifdef FETCH_HALT_DETECT_EN
  logic r_halted;

  assign w_is_halt = (imem_rdata[15:11] == 5'b00000);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_halted <= 1'b0;
    end else if (redirect_valid) begin
      r_halted <= 1'b0;
    end else if (w_push && w_is_halt) begin
      r_halted <= 1'b1;
    end
  end

  assign w_halted = r_halted;
`else
  assign w_is_halt = 1'b0;
  assign w_halted  = 1'b0;
`endif

  // PC: a HALT is pushed but the PC stays on it so a later redirect/reset is
  // the only way forward.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc <= RESET_PC & 16'hFFFE;
    end else if (redirect_valid) begin
      r_pc <= redirect_pc & 16'hFFFE;
    end else if (w_push && !w_is_halt) begin
      r_pc <= w_pc + 16'd2;
    end
  end

  // Occupancy and pointers. When full with a simultaneous pop and push, head
  // and tail coincide; the head is read combinationally before the write lands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= 3'd0;
      r_head  <= '0;
      r_tail  <= '0;
    end else if (redirect_valid) begin
      r_count <= 3'd0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      if (w_push) begin
        r_tail <= next_ptr(r_tail);
      end
      if (w_pop) begin
        r_head <= next_ptr(r_head);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_inst[r_tail] <= imem_rdata;
      r_buf_pc[r_tail]   <= w_pc;
    end
  end

  assign imem_addr    = w_pc;
  assign imem_en      = w_push;
  assign inst_valid   = w_not_empty;
  assign inst_out     = w_not_empty ? r_buf_inst[r_head] : 16'h0000;
  assign pc_out       = w_not_empty ? r_buf_pc[r_head] : 16'h0000;
  assign pc_plus2_out = w_not_empty ? (r_buf_pc[r_head] + 16'd2) : 16'h0000;
  assign halted       = w_halted;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit

module tb_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [15:0] RESET_PC = 16'h0000;
`ifdef FETCH_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] imem_addr;
  logic        imem_en;
  logic [15:0] imem_rdata;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [15:0] inst_out;
  logic [15:0] pc_out;
  logic [15:0] pc_plus2_out;
  logic        halted;
  logic        halt_inject;

  int n_vec;
  int n_mis;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_en(imem_en), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_out(inst_out), .pc_out(pc_out), .pc_plus2_out(pc_plus2_out),
    .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: word at byte address a is {1,a[15:1]} ^ 16'h2000, so
  // 0x0000 -> A000, 0x0002 -> A001. Optionally 0x0006 holds 0x0000 (HALT).
  function automatic logic [15:0] word_at(input logic [15:0] a, input logic inj);
    if (inj && a == 16'h0006) return 16'h0000;
    return {1'b1, a[15:1]} ^ 16'h2000;
  endfunction

  assign imem_rdata = word_at(imem_addr, halt_inject);

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue of fetched {pc, inst} pairs plus PC and halt flag.
  typedef struct { logic [15:0] pc; logic [15:0] inst; } ent_t;
  ent_t        mq[$];
  logic [15:0] mpc;
  logic        mhalt;

  task automatic model_reset();
    mq.delete();
    mpc   = RESET_PC & 16'hFFFE;
    mhalt = 1'b0;
  endtask

  // One cycle: drive inputs, compare at the falling edge, advance the model.
  task automatic tick(input logic rv, input logic [15:0] rp, input logic rdy);
    logic        pop;
    logic        go;
    logic [15:0] w;
    redirect_valid = rv;
    redirect_pc    = rp;
    inst_ready     = rdy;
    @(negedge clk);
    pop = (mq.size() != 0) && rdy && !rv;
    go  = !rv && !mhalt && ((mq.size() < DEPTH) || pop);
    chk("imem_en", {15'd0, imem_en}, {15'd0, go});
    chk("imem_addr", imem_addr, mpc);
    chk("inst_valid", {15'd0, inst_valid}, {15'd0, mq.size() != 0});
    if (mq.size() != 0) begin
      chk("inst_out", inst_out, mq[0].inst);
      chk("pc_out", pc_out, mq[0].pc);
      chk("pc_plus2_out", pc_plus2_out, mq[0].pc + 16'd2);
    end else begin
      chk("inst_out_empty", inst_out, 16'h0000);
      chk("pc_out_empty", pc_out, 16'h0000);
      chk("pc_plus2_empty", pc_plus2_out, 16'h0000);
    end
    chk("halted", {15'd0, halted}, {15'd0, mhalt});
    if (rv) begin
      mq.delete();
      mpc   = rp & 16'hFFFE;
      mhalt = 1'b0;
    end else begin
      w = word_at(mpc, halt_inject);
      if (pop) void'(mq.pop_front());
      if (go) begin
        mq.push_back('{pc: mpc, inst: w});
        if (HALT_EN && w[15:11] == 5'b00000) mhalt = 1'b1;
        else mpc = mpc + 16'd2;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    inst_ready     = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic        rst_n;
    logic        rv;
    logic [15:0] rpc;
    logic        rdy;
    logic        en;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] inst;
    logic [15:0] pc;
    logic [15:0] p2;
  } vec_t;

  function automatic vec_t mk(input logic rs, input logic rv, input logic [15:0] rpc,
                              input logic rdy, input logic en, input logic [15:0] addr,
                              input logic vl, input logic [15:0] inst,
                              input logic [15:0] pc, input logic [15:0] p2);
    vec_t v;
    v.rst_n = rs; v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.en = en;
    v.addr = addr; v.valid = vl; v.inst = inst; v.pc = pc; v.p2 = p2;
    return v;
  endfunction

  vec_t tbl[21];

  initial begin
    n_vec = 0;
    n_mis = 0;
    halt_inject    = 1'b0;
    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    inst_ready     = 1'b0;

    //          rst  rv  rpc      rdy en  addr     vld inst     pc       pc+2
    tbl[0]  = mk(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000);
    tbl[1]  = mk(1, 0, 16'h0000, 1, 1, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000);
    tbl[2]  = mk(1, 0, 16'h0000, 1, 1, 16'h0002, 1, 16'hA000, 16'h0000, 16'h0002);
    tbl[3]  = mk(1, 0, 16'h0000, 1, 1, 16'h0004, 1, 16'hA001, 16'h0002, 16'h0004);
    tbl[4]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000);
    tbl[5]  = mk(1, 0, 16'h0000, 0, 1, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000);
    tbl[6]  = mk(1, 0, 16'h0000, 0, 1, 16'h0002, 1, 16'hA000, 16'h0000, 16'h0002);
    tbl[7]  = mk(1, 0, 16'h0000, 0, 0, 16'h0004, 1, 16'hA000, 16'h0000, 16'h0002);
    tbl[8]  = mk(1, 0, 16'h0000, 0, 0, 16'h0004, 1, 16'hA000, 16'h0000, 16'h0002);
    tbl[9]  = mk(1, 0, 16'h0000, 0, 0, 16'h0004, 1, 16'hA000, 16'h0000, 16'h0002);
    tbl[10] = mk(1, 0, 16'h0000, 1, 1, 16'h0004, 1, 16'hA000, 16'h0000, 16'h0002);
    tbl[11] = mk(1, 0, 16'h0000, 1, 1, 16'h0006, 1, 16'hA001, 16'h0002, 16'h0004);
    tbl[12] = mk(1, 0, 16'h0000, 1, 1, 16'h0008, 1, 16'hA002, 16'h0004, 16'h0006);
    tbl[13] = mk(1, 0, 16'h0000, 0, 0, 16'h000A, 1, 16'hA003, 16'h0006, 16'h0008);
    tbl[14] = mk(1, 1, 16'h0101, 1, 0, 16'h000A, 1, 16'hA003, 16'h0006, 16'h0008);
    tbl[15] = mk(1, 0, 16'h0000, 1, 1, 16'h0100, 0, 16'h0000, 16'h0000, 16'h0000);
    tbl[16] = mk(1, 0, 16'h0000, 1, 1, 16'h0102, 1, 16'hA080, 16'h0100, 16'h0102);
    tbl[17] = mk(1, 1, 16'hFFFE, 1, 0, 16'h0104, 1, 16'hA081, 16'h0102, 16'h0104);
    tbl[18] = mk(1, 0, 16'h0000, 1, 1, 16'hFFFE, 0, 16'h0000, 16'h0000, 16'h0000);
    tbl[19] = mk(1, 0, 16'h0000, 1, 1, 16'h0000, 1, 16'hDFFF, 16'hFFFE, 16'h0000);
    tbl[20] = mk(1, 0, 16'h0000, 1, 1, 16'h0002, 1, 16'hA000, 16'h0000, 16'h0002);

    @(posedge clk);
    #1;
    for (int i = 0; i < 21; i++) begin
      rst            = tbl[i].rst_n;
      redirect_valid = tbl[i].rv;
      redirect_pc    = tbl[i].rpc;
      inst_ready     = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("t%0d_imem_en", i), {15'd0, imem_en}, {15'd0, tbl[i].en});
      chk($sformatf("t%0d_imem_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("t%0d_inst_valid", i), {15'd0, inst_valid}, {15'd0, tbl[i].valid});
      chk($sformatf("t%0d_inst_out", i), inst_out, tbl[i].inst);
      chk($sformatf("t%0d_pc_out", i), pc_out, tbl[i].pc);
      chk($sformatf("t%0d_pc_plus2", i), pc_plus2_out, tbl[i].p2);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset between edges with two entries buffered.
    do_reset();
    tick(1'b0, 16'h0000, 1'b0);
    tick(1'b0, 16'h0000, 1'b0);
    tick(1'b0, 16'h0000, 1'b0);
    chk("async_pre_valid", {15'd0, inst_valid}, 16'h0001);
    #2;
    rst = 1'b0;
    #1;
    chk("async_valid", {15'd0, inst_valid}, 16'h0000);
    chk("async_pc", imem_addr, RESET_PC);
    chk("async_en", {15'd0, imem_en}, 16'h0000);
    chk("async_inst", inst_out, 16'h0000);

`ifdef FETCH_HALT_DETECT_EN
    // HALT word at 0x0006: delivered, then fetching stops until a redirect.
    do_reset();
    halt_inject = 1'b1;
    for (int i = 0; i < 4; i++) tick(1'b0, 16'h0000, 1'b1);
    chk("halt_set", {15'd0, halted}, 16'h0001);
    chk("halt_en", {15'd0, imem_en}, 16'h0000);
    chk("halt_inst", inst_out, 16'h0000);
    chk("halt_pc_out", pc_out, 16'h0006);
    tick(1'b0, 16'h0000, 1'b1);
    tick(1'b0, 16'h0000, 1'b1);
    chk("halt_hold_en", {15'd0, imem_en}, 16'h0000);
    tick(1'b1, 16'h0010, 1'b1);
    chk("halt_clear", {15'd0, halted}, 16'h0000);
    chk("halt_redir_addr", imem_addr, 16'h0010);
    tick(1'b0, 16'h0000, 1'b1);
`endif

    // Randomized traffic against the model; HALT word present at 0x0006.
    do_reset();
    halt_inject = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      logic        rv;
      logic [15:0] rp;
      logic        rdy;
      rv  = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 2))
        0:       rp = 16'($urandom);
        1:       rp = 16'hFFFA + 16'($urandom_range(0, 5));
        default: rp = 16'($urandom_range(0, 15));
      endcase
      rdy = ($urandom_range(0, 3) != 0);
      tick(rv, rp, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
